// File: rtl/count_sequencer_pkg.sv
// rtl/count_sequencer_pkg.sv - shared states, modes and default widths for count_sequencer
package count_sequencer_pkg;

   localparam int CNT_SZ_DEFAULT = 8;
   localparam int DIV_SZ_DEFAULT = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/count_sequencer_rate_prescaler.sv
// rtl/count_sequencer_rate_prescaler.sv - rate divider counting 0..div_q-1 with terminal-count tick
module rate_prescaler
   import count_sequencer_pkg::*;
#(
   parameter int DIV_SZ = DIV_SZ_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              enable,
   input  logic [DIV_SZ-1:0] div_q,
   output logic              tick
);

   logic [DIV_SZ-1:0] cnt;

   // div_q is never 0 here; the sequencer clamps it to 1 when latching
   assign tick = enable && (cnt == div_q - DIV_SZ'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tick ? '0 : cnt + DIV_SZ'(1);
      end
   end

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - enable-strobe sequencer for 8-bit counters: one-shot bursts or continuous runs
module count_sequencer
   import count_sequencer_pkg::*;
#(
   parameter int CNT_SZ = CNT_SZ_DEFAULT,
   parameter int DIV_SZ = DIV_SZ_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              mode,
   input  logic [DIV_SZ-1:0] div,
   input  logic [CNT_SZ-1:0] burst_len,
   output logic              count_en,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [CNT_SZ-1:0] issued
);

   state_t            state, state_d;
   logic [DIV_SZ-1:0] div_q, div_d;
   logic [CNT_SZ-1:0] len_q, len_d;
   logic              mode_q, mode_d;
   logic [CNT_SZ-1:0] issued_d, issued_inc;
   logic              count_en_d, done_d, aborted_d;
   logic              pre_clear, pre_enable, tick;

   rate_prescaler #(.DIV_SZ(DIV_SZ)) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (pre_clear),
      .enable  (pre_enable),
      .div_q   (div_q),
      .tick    (tick)
   );

   assign issued_inc = issued + CNT_SZ'(1);
   assign busy       = (state == ST_RUN);

   always_comb begin
      state_d    = state;
      div_d      = div_q;
      len_d      = len_q;
      mode_d     = mode_q;
      issued_d   = issued;
      count_en_d = 1'b0;
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      pre_clear  = 1'b0;
      pre_enable = 1'b0;
      case (state)
         ST_IDLE: begin
            pre_clear = 1'b1;
            if (start) begin
               state_d  = ST_RUN;
               div_d    = (div == '0) ? DIV_SZ'(1) : div;
               len_d    = burst_len;
               mode_d   = mode;
               issued_d = '0;
            end
         end
         ST_RUN: begin
            // stop wins over a strobe that would fire on the same edge
            if (stop) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else begin
               pre_enable = 1'b1;
               if (tick) begin
                  count_en_d = 1'b1;
                  issued_d   = issued_inc;
                  // len_q == 0 matches when issued wraps, giving 2^CNT_SZ strobes
                  if (mode_q == MODE_ONESHOT && issued_inc == len_q) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         div_q    <= '0;
         len_q    <= '0;
         mode_q   <= MODE_ONESHOT;
         issued   <= '0;
         count_en <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         state    <= state_d;
         div_q    <= div_d;
         len_q    <= len_d;
         mode_q   <= mode_d;
         issued   <= issued_d;
         count_en <= count_en_d;
         done     <= done_d;
         aborted  <= aborted_d;
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer
module tb_count_sequencer;

   logic        clock, reset_n, start, stop, mode;
   logic [15:0] div;
   logic [7:0]  burst_len;
   logic        count_en, busy, done, aborted;
   logic [7:0]  issued;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int          cyc;
      logic [11:0] flags;
   } exp_t;

   exp_t exp_q[$];

   count_sequencer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .div       (div),
      .burst_len (burst_len),
      .count_en  (count_en),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .issued    (issued)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, expv, cyc);
      end
   endtask

   // flags = {busy, done, aborted, count_en, issued}
   function automatic logic [11:0] fl(input logic b, input logic d, input logic a,
                                      input logic c, input int iss);
      logic [7:0] i8;
      i8 = iss[7:0];
      return {b, d, a, c, i8};
   endfunction

   task automatic push(input int c, input logic [11:0] f);
      exp_t e;
      e.cyc   = c;
      e.flags = f;
      exp_q.push_back(e);
   endtask

   always @(negedge clock) begin
      if (reset_n && (count_en || done || aborted)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got ce=%0b done=%0b ab=%0b iss=%0d at cyc %0d, expected none",
                     count_en, done, aborted, issued, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("event_cycle", cyc, e.cyc);
            check("event_flags", int'({busy, done, aborted, count_en, issued}), int'(e.flags));
         end
      end
   end

   task automatic wait_until(input int n);
      for (int i = 0; i < 20000 && cyc < n; i++) begin
         @(posedge clock);
         #1;
      end
      if (cyc != n) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_bound: reached cyc %0d, expected %0d", cyc, n);
      end
   endtask

   task automatic go(input int d, input int len, input logic m, output int k);
      @(posedge clock);
      #1;
      div       = d[15:0];
      burst_len = len[7:0];
      mode      = m;
      start     = 1'b1;
      k         = cyc + 1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   initial begin
      int k, k2;
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
      div = '0; burst_len = '0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      #1 check("reset_outputs", int'({busy, done, aborted, count_en, issued}), 0);

      // async reset mid-run while a strobe is high
      go(3, 0, 1'b1, k);
      push(k + 3, fl(1, 0, 0, 1, 1));
      push(k + 6, fl(1, 0, 0, 1, 2));
      wait_until(k + 9);
      #1 check("strobe_before_reset", count_en, 1);
      reset_n = 1'b0;
      #1 check("async_reset_outputs", int'({busy, done, aborted, count_en, issued}), 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      wait_until(cyc + 10);
      check("idle_after_reset", busy, 0);

      // one-shot div=4 len=3
      go(4, 3, 1'b0, k);
      push(k + 4,  fl(1, 0, 0, 1, 1));
      push(k + 8,  fl(1, 0, 0, 1, 2));
      push(k + 12, fl(0, 1, 0, 1, 3));
      wait_until(k + 14);
      check("oneshot_issued", issued, 3);

      // div=0 and burst_len=0: 256 back-to-back strobes
      go(0, 0, 1'b0, k);
      for (int j = 1; j <= 256; j++)
         push(k + j, fl(j != 256, j == 256, 0, 1, j));
      wait_until(k + 258);
      check("wrap_burst_issued", issued, 0);

      // stop on the edge of the 5th strobe, start held alongside it
      go(2, 0, 1'b1, k);
      for (int j = 1; j <= 4; j++)
         push(k + 2 * j, fl(1, 0, 0, 1, j));
      push(k + 10, fl(0, 0, 1, 0, 4));
      wait_until(k + 9);
      stop  = 1'b1;
      start = 1'b1;
      @(posedge clock);
      #1;
      stop  = 1'b0;
      start = 1'b0;
      wait_until(k + 15);
      check("stop_issued", issued, 4);
      check("stop_idle", busy, 0);

      // start held high: no restart mid-burst, new burst one edge after done
      @(posedge clock);
      #1;
      div = 16'd2; burst_len = 8'd2; mode = 1'b0; start = 1'b1;
      k  = cyc + 1;
      k2 = k + 5;
      push(k + 2,  fl(1, 0, 0, 1, 1));
      push(k + 4,  fl(0, 1, 0, 1, 2));
      push(k2 + 2, fl(1, 0, 0, 1, 1));
      push(k2 + 4, fl(0, 1, 0, 1, 2));
      wait_until(k2);
      start = 1'b0;
      wait_until(k2 + 6);
      check("b2b_issued", issued, 2);

      // div/burst_len/mode changes mid-run are ignored
      go(3, 3, 1'b0, k);
      div = 16'd1; burst_len = 8'd1; mode = 1'b1;
      push(k + 3, fl(1, 0, 0, 1, 1));
      push(k + 6, fl(1, 0, 0, 1, 2));
      push(k + 9, fl(0, 1, 0, 1, 3));
      wait_until(k + 11);
      check("midrun_change_issued", issued, 3);

      // continuous div=1 for 300 strobes, then stop
      go(1, 0, 1'b1, k);
      for (int j = 1; j <= 300; j++)
         push(k + j, fl(1, 0, 0, 1, j));
      push(k + 301, fl(0, 0, 1, 0, 300));
      wait_until(k + 300);
      stop = 1'b1;
      @(posedge clock);
      #1 stop = 1'b0;
      wait_until(k + 305);
      check("cont_idle", busy, 0);
      check("cont_issued", issued, 44);

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
